nes_pad_responder: RTL and testbench
====================================

Name: nes_pad_responder

Overview:
- Device end of the NES controller serial link: emulates a standard pad's 4021 shift register so the FPGA can act as a controller toward a real console or the host-side poller.
- Samples an 8-bit active-high button vector on latch and shifts it out active-low, one bit per pulse rising edge.
- Latch and pulse arrive asynchronously from the external host.
- Sits between the button source (test logic, UART bridge, etc.) and the pad connector pins.

Parameters:
- FILTER_CYCLES, 3: consecutive stable synchronized samples required before latch/pulse level change is accepted (min 1).
- TAIL_LEVEL, 0: data_out level driven after all 8 bits are shifted (0 = line low, like an official pad).

Ports:
- clock  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- enable  in  1  1 = respond to host; 0 = force IDLE, data_out = 1
- buttons  in  8  active-high: [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right
- latch_in  in  1  async latch from host, active-high
- pulse_in  in  1  async shift clock from host, active-high
- data_out  out  1  serial data to host, active-low, registered
- polled  out  1  one-cycle strobe when the 8th bit has been shifted
- busy  out  1  high in LOAD or SHIFT

Behaviour:
- Reset values: data_out=1, polled=0, busy=0, state=IDLE, shift reg=0, bit_cnt=0, sync/filter flops=0.
- Input path per signal: 2-flop synchronizer, then filter. Filtered level flips only after the synced level differs from it for FILTER_CYCLES consecutive cycles. Rise/fall strobes come from the filtered level.
- Pin-to-data_out latency is exactly 2 + FILTER_CYCLES + 1 cycles (6 at defaults, 120 ns). This is well inside the host's 6 µs half-period.
- States:
  - IDLE: data_out=1. On latch rise with enable=1, go to LOAD.
  - LOAD: shift reg = ~buttons every cycle. data_out = ~buttons[0] (registered). bit_cnt=0. On latch fall, freeze the shift reg and go to SHIFT.
  - SHIFT: on each pulse rise, shift right, bit_cnt+1, data_out = next bit. The vacated MSB fills with TAIL_LEVEL. When bit_cnt reaches 8, assert polled for 1 cycle and go to DONE.
  - DONE: data_out = TAIL_LEVEL. Extra pulse rises are ignored and bit_cnt saturates at 8. On latch rise, go to LOAD.
- The button snapshot is the buttons value sampled in the last LOAD cycle before the latch-fall strobe. Button changes during SHIFT do not affect output.
- Bit order on the wire: A first, then B, Select, Start, Up, Down, Left, Right.
- Latch rise while in SHIFT aborts the read and goes to LOAD; no polled strobe.
- Pulse rise while latch is filtered-high is ignored (load dominates).
- Latch rise and pulse rise in the same cycle: the latch rise wins.
- enable deasserted in any state: next cycle state=IDLE, data_out=1, polled=0. Reassertion waits for a fresh latch rise.
- Reset mid-operation: all registers return to reset values on the next edge.
- busy = (state==LOAD || state==SHIFT), registered.

Decomposition:
- Shared package nes_pkg:
  - button index constants BTN_A..BTN_RIGHT = 0..7, also used by the host-side poller;
  - NES_BITS=8;
  - state encoding IDLE/LOAD/SHIFT/DONE.
- Sub-module nes_input_filter: synchronizer, FILTER_CYCLES stability counter, and rise/fall strobes. Instantiated twice, for latch and pulse.

Test Plan:
- buttons=8'b0000_0101 (A, Select), latch 12 µs, then 8 pulses of 6 µs high/6 µs low -> data_out sequence 0,1,0,1,1,1,1,1; polled high once, 1 cycle after the 8th edge plus latency; then data_out=0.
- Same frame with a 9th and 10th pulse -> data_out stays 0, no second polled, bit_cnt=8.
- buttons change 8'h01 -> 8'h80 after 3 pulses -> remaining bits still from 8'h01 (all 1 on wire); next frame reads Right (bit 7 = 0).
- Latch reasserted after 4 pulses -> return to LOAD, no polled; new frame reads the fresh buttons correctly.
- 2-cycle glitch on pulse_in (FILTER_CYCLES=3) -> no shift, data_out unchanged. A 4-cycle pulse shifts exactly once.
- reset asserted and, separately, enable dropped after 5 pulses -> data_out=1, busy=0, polled never asserted; next full frame with buttons=8'hFF reads eight 0s.

Source files
------------

// File: rtl/nes_pkg.sv
// Shared NES pad definitions: button bit positions, frame length and responder state encoding.
package nes_pkg;

    localparam int unsigned NES_BITS  = 8;
    localparam int unsigned CNT_W     = 4;

    localparam int unsigned BTN_A      = 0;
    localparam int unsigned BTN_B      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } nes_state_e;

endpackage

// File: rtl/nes_input_filter.sv
// Two-flop synchronizer plus stability filter for one asynchronous host line.
// The filtered level and its registered rise/fall strobes change on the same edge.
module nes_input_filter #(
    parameter int unsigned FILTER_CYCLES = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          rise_q, fall_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          flip_c;

    // Flip once the synced level has disagreed for FILTER_CYCLES consecutive cycles.
    always_comb begin
        flip_c  = (sync2_q != level_q) && (cnt_q == CW'(FILTER_CYCLES - 1));
        level_d = level_q;
        cnt_d   = '0;
        if (flip_c) begin
            level_d = sync2_q;
        end else if (sync2_q != level_q) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= flip_c & sync2_q;
            fall_q  <= flip_c & ~sync2_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/nes_pad_responder.sv
// Device side of the NES pad link: emulates the 4021 shift register, snapshotting
// the active-high buttons on latch and shifting them out active-low on pulse rises.
module nes_pad_responder
    import nes_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES = 3,
    parameter logic        TAIL_LEVEL    = 1'b0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [NES_BITS-1:0] buttons,
    input  logic                latch_in,
    input  logic                pulse_in,
    output logic                data_out,
    output logic                polled,
    output logic                busy
);

    nes_state_e          state_q, state_d;
    logic [NES_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                data_q, data_d;
    logic                polled_q, polled_d;
    logic                busy_q, busy_d;

    logic latch_level_c, latch_rise_c, latch_fall_c;
    logic pulse_level_c, pulse_rise_c, pulse_fall_c;
    logic unused_c;

    nes_input_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_latch_filter (
        .clock   (clock),
        .reset   (reset),
        .pin_i   (latch_in),
        .level_o (latch_level_c),
        .rise_o  (latch_rise_c),
        .fall_o  (latch_fall_c)
    );

    nes_input_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_pulse_filter (
        .clock   (clock),
        .reset   (reset),
        .pin_i   (pulse_in),
        .level_o (pulse_level_c),
        .rise_o  (pulse_rise_c),
        .fall_o  (pulse_fall_c)
    );

    assign unused_c = pulse_level_c ^ pulse_fall_c;

    // Latch rise takes priority over everything but enable; it (re)starts a frame.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        polled_d  = 1'b0;

        if (!enable) begin
            state_d = ST_IDLE;
            data_d  = 1'b1;
        end else if (latch_rise_c) begin
            state_d   = ST_LOAD;
            shift_d   = ~buttons;
            data_d    = ~buttons[BTN_A];
            bit_cnt_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    data_d = 1'b1;
                end
                ST_LOAD: begin
                    if (latch_fall_c) begin
                        state_d = ST_SHIFT;
                    end else begin
                        shift_d   = ~buttons;
                        data_d    = ~buttons[BTN_A];
                        bit_cnt_d = '0;
                    end
                end
                ST_SHIFT: begin
                    if (pulse_rise_c && !latch_level_c) begin
                        shift_d   = {TAIL_LEVEL, shift_q[NES_BITS-1:1]};
                        data_d    = shift_q[1];
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(NES_BITS - 1)) begin
                            polled_d = 1'b1;
                            state_d  = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    data_d = TAIL_LEVEL;
                end
                default: begin
                    state_d = ST_IDLE;
                    data_d  = 1'b1;
                end
            endcase
        end

        busy_d = (state_d == ST_LOAD) || (state_d == ST_SHIFT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            data_q    <= 1'b1;
            polled_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            polled_q  <= polled_d;
            busy_q    <= busy_d;
        end
    end

    assign data_out = data_q;
    assign polled   = polled_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_nes_pad_responder.sv
// Directed bench for nes_pad_responder: an 8-bit pad model feeds expected wire bits
// into a scoreboard queue, popped and compared once each host half-period settles.
module tb_nes_pad_responder;
    import nes_pkg::*;

    localparam int unsigned LATCH_CY = 600;   // 12 us at 50 MHz
    localparam int unsigned HALF_CY  = 300;   // 6 us
    localparam logic        TAIL     = 1'b0;

    logic       clock = 1'b0;
    logic       reset, enable, latch_in, pulse_in;
    logic [7:0] buttons;
    logic       data_out, polled, busy;

    int compared   = 0;
    int mismatched = 0;
    int polled_cnt = 0;
    int nshift     = 0;
    int p0         = 0;
    logic [7:0] mdl = 8'h00;
    logic       exp_q[$];

    always #10 clock = ~clock;

    nes_pad_responder dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .buttons  (buttons),
        .latch_in (latch_in),
        .pulse_in (pulse_in),
        .data_out (data_out),
        .polled   (polled),
        .busy     (busy)
    );

    always @(posedge clock) if (polled === 1'b1) polled_cnt <= polled_cnt + 1;

    task automatic wait_cy(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_bit();
        exp_q.push_back(mdl[0]);
    endtask

    task automatic check_bit(input string tag);
        logic e;
        if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL %s: observed empty-queue expected one entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 8'(data_out), 8'(e));
        end
    endtask

    task automatic latch_frame(input logic [7:0] btn, input string tag);
        buttons  = btn;
        latch_in = 1'b1;
        wait_cy(LATCH_CY);
        mdl      = ~btn;
        nshift   = 0;
        latch_in = 1'b0;
        wait_cy(HALF_CY);
        push_bit();
        check_bit({tag, "_bit0"});
    endtask

    // One host pulse; the 8th shift is also checked for exact polled timing.
    task automatic do_pulse(input string tag);
        bit timed;
        timed    = (nshift == 7);
        pulse_in = 1'b1;
        if (timed) begin
            wait_cy(5);
            chk({tag, "_polled_early"}, 8'(polled), 8'h00);
            wait_cy(1);
            chk({tag, "_polled_edge"}, 8'(polled), 8'h01);
            chk({tag, "_tail_edge"}, 8'(data_out), 8'(TAIL));
            wait_cy(HALF_CY - 6);
        end else begin
            wait_cy(HALF_CY);
        end
        pulse_in = 1'b0;
        wait_cy(HALF_CY);
        if (nshift < 8) begin
            mdl    = {TAIL, mdl[7:1]};
            nshift = nshift + 1;
        end
        push_bit();
        check_bit({tag, "_bit"});
    endtask

    initial begin
        reset    = 1'b1;
        enable   = 1'b1;
        latch_in = 1'b0;
        pulse_in = 1'b0;
        buttons  = 8'h00;
        wait_cy(3);
        chk("rst_data", 8'(data_out), 8'h01);
        chk("rst_polled", 8'(polled), 8'h00);
        chk("rst_busy", 8'(busy), 8'h00);
        reset = 1'b0;
        wait_cy(2);

        // A + Select, then two extra pulses past the end of the frame
        p0 = polled_cnt;
        latch_frame(8'h05, "f05");
        chk("f05_busy", 8'(busy), 8'h01);
        for (int i = 0; i < 8; i++) do_pulse("f05");
        chk("f05_busy_done", 8'(busy), 8'h00);
        chk("f05_polled_once", 8'(polled_cnt - p0), 8'h01);
        do_pulse("f05_x9");
        do_pulse("f05_x10");
        chk("f05_no_second_poll", 8'(polled_cnt - p0), 8'h01);
        chk("f05_bitcnt_sat", 8'(dut.bit_cnt_q), 8'h08);

        // Buttons change mid-shift must not leak into the frame
        latch_frame(8'h01, "f01");
        for (int i = 0; i < 3; i++) do_pulse("f01");
        buttons = 8'h80;
        for (int i = 0; i < 5; i++) do_pulse("f01_chg");
        latch_frame(8'h80, "f80");
        for (int i = 0; i < 8; i++) do_pulse("f80");

        // Latch abort after 4 pulses
        p0 = polled_cnt;
        latch_frame(8'h33, "f33");
        for (int i = 0; i < 4; i++) do_pulse("f33");
        latch_frame(8'h5A, "f5a");
        chk("abort_no_poll", 8'(polled_cnt - p0), 8'h00);
        for (int i = 0; i < 8; i++) do_pulse("f5a");
        chk("f5a_polled_once", 8'(polled_cnt - p0), 8'h01);

        // Glitch rejection: 2-cycle pulse ignored, 4-cycle pulse shifts once
        latch_frame(8'hC3, "fc3");
        pulse_in = 1'b1;
        wait_cy(2);
        pulse_in = 1'b0;
        wait_cy(50);
        push_bit();
        check_bit("glitch_bit");
        chk("glitch_bitcnt", 8'(dut.bit_cnt_q), 8'h00);
        pulse_in = 1'b1;
        wait_cy(4);
        pulse_in = 1'b0;
        wait_cy(50);
        mdl    = {TAIL, mdl[7:1]};
        nshift = 1;
        push_bit();
        check_bit("short_pulse_bit");
        chk("short_pulse_bitcnt", 8'(dut.bit_cnt_q), 8'h01);
        for (int i = 0; i < 7; i++) do_pulse("fc3");

        // Reset mid-frame
        p0 = polled_cnt;
        latch_frame(8'h0F, "rst_f");
        for (int i = 0; i < 5; i++) do_pulse("rst_f");
        reset = 1'b1;
        wait_cy(2);
        chk("midrst_data", 8'(data_out), 8'h01);
        chk("midrst_busy", 8'(busy), 8'h00);
        chk("midrst_state", 8'(dut.state_q), 8'(ST_IDLE));
        reset = 1'b0;
        wait_cy(2);

        // Enable drop mid-frame; re-enable must wait for a fresh latch
        latch_frame(8'h0F, "en_f");
        for (int i = 0; i < 5; i++) do_pulse("en_f");
        enable = 1'b0;
        wait_cy(2);
        chk("endrop_data", 8'(data_out), 8'h01);
        chk("endrop_busy", 8'(busy), 8'h00);
        chk("endrop_state", 8'(dut.state_q), 8'(ST_IDLE));
        enable = 1'b1;
        wait_cy(10);
        pulse_in = 1'b1;
        wait_cy(HALF_CY);
        pulse_in = 1'b0;
        wait_cy(HALF_CY);
        chk("reen_no_latch_data", 8'(data_out), 8'h01);
        chk("abort_paths_no_poll", 8'(polled_cnt - p0), 8'h00);

        latch_frame(8'hFF, "fff");
        for (int i = 0; i < 8; i++) do_pulse("fff");
        chk("fff_polled_once", 8'(polled_cnt - p0), 8'h01);
        chk("queue_drained", 8'(exp_q.size()), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
